detector_jogada: RTL and testbench

- Input conditioning stage directly upstream of the game datapath/FSM in circuito_exp7.
- Takes the raw asynchronous `botoes` bus, then synchronizes, debounces and validates it.
- Emits one single-cycle `jogada_feita` pulse per distinct press, with a registered one-hot `jogada` value.
- Multi-button presses are rejected and flagged. A new press is accepted only after all buttons have been released.

---
 rtl/detector_jogada.sv | 170 +++++++++++++++++
 tb/tb_detector_jogada.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - button synchronizer, debouncer and press validator
//
// Purpose:
//   Conditions the raw, asynchronous button bus before it reaches the game
//   datapath. The bus is synchronized, debounced and validated. One
//   single-cycle jogada_feita pulse is produced for each distinct one-hot
//   press. Multi-button presses are rejected and flagged on multiplos.
//   A new press is accepted only after every button has been released.
//
// Ports:
//   clock        in   1         system clock
//   reset        in   1         synchronous, active-high
//   habilita     in   1         accept new presses only while high
//   botoes       in   N_BOTOES  raw button levels, asynchronous
//   jogada       out  N_BOTOES  last accepted one-hot value, registered and held
//   jogada_feita out  1         one-cycle pulse: valid press accepted
//   multiplos    out  1         one-cycle pulse: multi-button press rejected
//   db_estado    out  4         current FSM state code {2'b00, state}

module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int N_BOTOES        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                habilita,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] jogada,
  output logic                jogada_feita,
  output logic                multiplos,
  output logic [3:0]          db_estado
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW:0] DB_LIM = (CW+1)'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    ARMADO = 2'd0,
    FILTRA = 2'd1,
    EMITE  = 2'd2,
    SOLTA  = 2'd3
  } estado_t;

  function automatic logic is_onehot(input logic [N_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  // Synchronizer and state registers.
  logic [N_BOTOES-1:0] botoes_meta;
  logic [N_BOTOES-1:0] s;
  logic [1:0]          sync_vld;
  logic [CW-1:0]       cnt;
  logic [N_BOTOES-1:0] cand;
  estado_t             estado;

  // Next-state values.
  estado_t             estado_next;
  logic [CW-1:0]       cnt_next;
  logic [N_BOTOES-1:0] cand_next;
  logic [N_BOTOES-1:0] jogada_next;

  logic [CW-1:0]       cnt_inc;
  logic [CW:0]         cnt_plus;
  logic                s_zero;
  logic                sync_ok;

  // The synchronizer holds zeros just after reset. Those zeros say nothing
  // about the buttons, so SOLTA must not count them as a release. Without
  // this guard, a button held through reset would be accepted.
  assign sync_ok  = sync_vld[1];
  assign s_zero   = (s == '0);
  assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
  assign cnt_plus = {1'b0, cnt} + 1'b1;

  always_ff @(posedge clock) begin
    if (reset) begin
      botoes_meta <= '0;
      s           <= '0;
      sync_vld    <= 2'b00;
      cnt         <= '0;
      cand        <= '0;
      jogada      <= '0;
      estado      <= SOLTA;
    end else begin
      botoes_meta <= botoes;
      s           <= botoes_meta;
      sync_vld    <= {sync_vld[0], 1'b1};
      cnt         <= cnt_next;
      cand        <= cand_next;
      jogada      <= jogada_next;
      estado      <= estado_next;
    end
  end

  always_comb begin
    estado_next = estado;
    cnt_next    = cnt;
    cand_next   = cand;
    jogada_next = jogada;

    case (estado)
      ARMADO: begin
        if (habilita && !s_zero) begin
          cand_next   = s;
          cnt_next    = CW'(1);
          estado_next = (DEBOUNCE_CYCLES == 1) ? EMITE : FILTRA;
        end else if (!habilita && !s_zero) begin
          // A press seen while disabled has to be released before
          // another one can count. Raising habilita mid-hold then
          // produces no pulse.
          cnt_next    = '0;
          estado_next = SOLTA;
        end
      end

      FILTRA: begin
        if (!habilita) begin
          cnt_next    = '0;
          estado_next = SOLTA;
        end else if (s == cand) begin
          cnt_next = cnt_inc;
          if (cnt_plus == DB_LIM) begin
            estado_next = EMITE;
          end
        end else if (s_zero) begin
          cnt_next    = '0;
          estado_next = ARMADO;
        end else begin
          // The contacts bounced to another pattern; restart on it.
          cand_next = s;
          cnt_next  = CW'(1);
        end
      end

      EMITE: begin
        cnt_next    = '0;
        estado_next = SOLTA;
      end

      SOLTA: begin
        if (!sync_ok || !s_zero) begin
          cnt_next = '0;
        end else begin
          cnt_next = cnt_inc;
          if (cnt_plus == DB_LIM) begin
            estado_next = ARMADO;
          end
        end
      end

      default: begin
        cnt_next    = '0;
        estado_next = SOLTA;
      end
    endcase

    // Load jogada on the edge that enters EMITE. The value is then valid
    // in the same cycle that the pulse is high.
    if (estado_next == EMITE && estado != EMITE && is_onehot(cand_next)) begin
      jogada_next = cand_next;
    end
  end

  // Moore pulses of EMITE. They are gated by reset so that a reset
  // arriving during EMITE suppresses the pulse in that cycle too.
  assign jogada_feita = (estado == EMITE) && is_onehot(cand) && !reset;
  assign multiplos    = (estado == EMITE) && !is_onehot(cand) && !reset;
  assign db_estado    = {2'b00, estado};

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - directed self-checking bench for detector_jogada

module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       habilita;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       jogada_feita;
  logic       multiplos;
  logic [3:0] db_estado;

  int n_checks = 0;
  int n_fail   = 0;
  int n_pulse  = 0;
  int n_mult   = 0;
  int n_both   = 0;
  int lat      = 0;

  detector_jogada #(
    .DEBOUNCE_CYCLES(2),
    .N_BOTOES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .habilita(habilita),
    .botoes(botoes),
    .jogada(jogada),
    .jogada_feita(jogada_feita),
    .multiplos(multiplos),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive botoes for n cycles. Outputs are sampled on the falling edge.
  task automatic step(input int n, input logic [3:0] b);
    for (int i = 0; i < n; i++) begin
      botoes = b;
      @(posedge clock);
      @(negedge clock);
      if (jogada_feita) n_pulse++;
      if (multiplos) n_mult++;
      if (jogada_feita && multiplos) n_both++;
    end
  endtask

  task automatic clear_counts();
    n_pulse = 0;
    n_mult  = 0;
  endtask

  initial begin
    clock    = 1'b0;
    reset    = 1'b1;
    habilita = 1'b0;
    botoes   = 4'b0000;
    @(negedge clock);
    step(2, 4'b0000);
    check("rst_jogada", 32'(jogada), 32'h0);
    check("rst_feita", 32'(jogada_feita), 32'h0);
    check("rst_mult", 32'(multiplos), 32'h0);
    check("rst_estado", 32'(db_estado), 32'h3);

    reset    = 1'b0;
    habilita = 1'b1;
    step(4, 4'b0000);
    check("armado_after_reset", 32'(db_estado), 32'h0);

    // Clean press: the pulse comes DEBOUNCE_CYCLES+2 = 4 edges after the first sampling edge.
    clear_counts();
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      step(1, (i <= 3) ? 4'b0100 : 4'b0000);
      if (jogada_feita && lat == 0) lat = i;
    end
    check("press_latency", 32'(lat), 32'd4);
    check("press_pulses", 32'(n_pulse), 32'd1);
    check("press_mult", 32'(n_mult), 32'd0);
    check("press_jogada", 32'(jogada), 32'h4);
    check("press_back_armado", 32'(db_estado), 32'h0);

    // Glitch of one cycle is rejected.
    clear_counts();
    step(1, 4'b0010);
    step(5, 4'b0000);
    check("glitch_pulses", 32'(n_pulse), 32'd0);
    check("glitch_mult", 32'(n_mult), 32'd0);
    check("glitch_jogada", 32'(jogada), 32'h4);
    check("glitch_estado", 32'(db_estado), 32'h0);

    // Bounce followed by a stable press.
    clear_counts();
    step(1, 4'b0001);
    step(1, 4'b0000);
    step(1, 4'b0001);
    step(3, 4'b0001);
    step(6, 4'b0000);
    check("bounce_pulses", 32'(n_pulse), 32'd1);
    check("bounce_jogada", 32'(jogada), 32'h1);

    // Two buttons together are flagged, not accepted.
    clear_counts();
    step(3, 4'b0011);
    step(6, 4'b0000);
    check("multi_mult", 32'(n_mult), 32'd1);
    check("multi_pulses", 32'(n_pulse), 32'd0);
    check("multi_jogada", 32'(jogada), 32'h1);

    // A long hold gives one pulse. A one-cycle release does not re-arm.
    clear_counts();
    step(50, 4'b1000);
    check("hold_pulses", 32'(n_pulse), 32'd1);
    check("hold_jogada", 32'(jogada), 32'h8);
    clear_counts();
    step(1, 4'b0000);
    step(3, 4'b0010);
    check("short_release_pulses", 32'(n_pulse), 32'd0);
    check("short_release_jogada", 32'(jogada), 32'h8);
    step(2, 4'b0000);
    step(3, 4'b0010);
    step(6, 4'b0000);
    check("rearm_pulses", 32'(n_pulse), 32'd1);
    check("rearm_jogada", 32'(jogada), 32'h2);

    // A press while disabled, then habilita rising mid-hold.
    clear_counts();
    habilita = 1'b0;
    step(3, 4'b0100);
    check("disabled_pulses", 32'(n_pulse), 32'd0);
    habilita = 1'b1;
    step(5, 4'b0100);
    check("enable_midhold_pulses", 32'(n_pulse), 32'd0);
    check("enable_midhold_estado", 32'(db_estado), 32'h3);
    step(2, 4'b0000);
    step(3, 4'b0100);
    step(6, 4'b0000);
    check("fresh_press_pulses", 32'(n_pulse), 32'd1);
    check("fresh_press_jogada", 32'(jogada), 32'h4);

    // Reset while in FILTRA with the button still held.
    clear_counts();
    step(3, 4'b0001);
    check("in_filtra", 32'(db_estado), 32'h1);
    reset = 1'b1;
    step(1, 4'b0001);
    check("midrst_jogada", 32'(jogada), 32'h0);
    check("midrst_feita", 32'(jogada_feita), 32'h0);
    check("midrst_mult", 32'(multiplos), 32'h0);
    check("midrst_estado", 32'(db_estado), 32'h3);
    reset = 1'b0;
    step(6, 4'b0001);
    check("held_through_reset_pulses", 32'(n_pulse), 32'd0);
    step(2, 4'b0000);
    step(3, 4'b0001);
    step(6, 4'b0000);
    check("after_reset_pulses", 32'(n_pulse), 32'd1);
    check("after_reset_jogada", 32'(jogada), 32'h1);

    // Reset arriving during EMITE suppresses the pulse in that same cycle.
    clear_counts();
    step(3, 4'b0010);
    @(posedge clock);
    #1;
    check("emite_reached", 32'(db_estado), 32'h2);
    reset = 1'b1;
    #1;
    check("emite_rst_feita", 32'(jogada_feita), 32'h0);
    check("emite_rst_mult", 32'(multiplos), 32'h0);
    @(negedge clock);
    step(1, 4'b0000);
    reset = 1'b0;
    check("emite_rst_jogada", 32'(jogada), 32'h0);
    check("emite_rst_estado", 32'(db_estado), 32'h3);
    step(4, 4'b0000);
    check("emite_rst_pulses", 32'(n_pulse), 32'd0);

    check("never_both", 32'(n_both), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
